// File: rtl/uart_pkg.sv
// uart_pkg: shared states and defaults for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_CNT_W = 10;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first framing of one byte onto a registered line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              tx_o,
  output logic              done_o
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic tx_q, tx_d, wrap;
  assign wrap = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  assign done_o = state_q == STOP && wrap;
  assign tx_o = tx_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  // Line level is derived from the next state so the start bit appears one cycle after the transfer.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shift_d = shift_q;
    cnt_d = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = START;
        shift_d = byte_i;
      end
      START: if (wrap) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 1'b1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX line by two byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              RsTx,
  output logic              busy,
  output logic              grant_id
);
  logic busy_q, busy_d, lock_q, lock_d, ptr_q, ptr_d, gid_q, gid_d;
  logic win, xfer, done, last_sel;
  logic [BYTE_W-1:0] data_sel;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      busy_q <= 1'b0;
      lock_q <= 1'b0;
      ptr_q <= 1'b0;
      gid_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      lock_q <= lock_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
    end
  // A held lock pins the winner to the owner, even while the owner has nothing to send.
  always_comb begin
    win = lock_q ? gid_q : (req0_valid && req1_valid) ? ptr_q : req1_valid;
    req0_ready = !rst && !busy_q && !win && req0_valid;
    req1_ready = !rst && !busy_q && win && req1_valid;
    xfer = req0_ready || req1_ready;
    data_sel = win ? req1_data : req0_data;
    last_sel = win ? req1_last : req0_last;
    busy_d = xfer ? 1'b1 : done ? 1'b0 : busy_q;
    gid_d = xfer ? win : gid_q;
    lock_d = xfer ? !last_sel : lock_q;
    ptr_d = (xfer && last_sel) ? !win : ptr_q;
  end
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_ser (
    .clk_i(sys_clk),
    .rst_i(rst),
    .start_i(xfer),
    .byte_i(data_sel),
    .tx_o(RsTx),
    .done_o(done)
  );
  assign busy = busy_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios with a frame scoreboard, CLKS_PER_BIT=4.
module tb_uart_tx_arbiter;
  typedef struct {logic [7:0] d; logic l;} src_t;
  typedef struct {logic [7:0] d; logic g;} exp_t;
  logic sys_clk = 0, rst = 1;
  logic req0_valid = 0, req0_last = 0, req1_valid = 0, req1_last = 0;
  logic [7:0] req0_data = 0, req1_data = 0;
  logic req0_ready, req1_ready, RsTx, busy, grant_id;
  logic acc0 = 0, acc1 = 0;
  int errors = 0, checks = 0, cyc = 0, r0_hi = 0, last_start = 0, prev_start = 0, bad, n;
  src_t s0[$], s1[$];
  exp_t sb[$];
  logic [8:0] acc_log[$];

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .CNT_W(3)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .RsTx(RsTx), .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic src(input bit id, input logic [7:0] d, input logic l);
    src_t s;
    s.d = d;
    s.l = l;
    if (id) s1.push_back(s); else s0.push_back(s);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic g);
    exp_t e;
    e.d = d;
    e.g = g;
    sb.push_back(e);
  endtask

  task automatic drive();
    req0_valid = s0.size() > 0;
    if (s0.size() > 0) begin req0_data = s0[0].d; req0_last = s0[0].l; end
    req1_valid = s1.size() > 0;
    if (s1.size() > 0) begin req1_data = s1[0].d; req1_last = s1[0].l; end
  endtask

  // One cycle: retire the byte accepted last cycle, drive, then sample mid-cycle.
  task automatic step();
    @(negedge sys_clk);
    cyc++;
    if (acc0) void'(s0.pop_front());
    if (acc1) void'(s1.pop_front());
    drive();
    #1;
    acc0 = req0_ready;
    acc1 = req1_ready;
    if (acc0) begin r0_hi++; acc_log.push_back({1'b0, req0_data}); end
    if (acc1) acc_log.push_back({1'b1, req1_data});
    chk("ready_excl", {31'd0, req0_ready & req1_ready}, 0);
  endtask

  task automatic recv(input string tag);
    exp_t e;
    logic [9:0] fr;
    int k2;
    k2 = 0;
    while (RsTx !== 1'b0 && k2 < 500) begin step(); k2++; end
    chk({tag, "_start_seen"}, {31'd0, k2 < 500}, 1);
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 1);
    if (k2 >= 500 || sb.size() == 0) return;
    prev_start = last_start;
    last_start = cyc;
    e = sb.pop_front();
    fr = {1'b1, e.d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 2 : 4) step();
      chk({tag, "_bit"}, {31'd0, RsTx}, {31'd0, fr[k]});
    end
    chk({tag, "_grant"}, {31'd0, grant_id}, {31'd0, e.g});
    step();
    chk({tag, "_busy_c39"}, {31'd0, busy}, 1);
    step();
    chk({tag, "_busy_c40"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_tx", {31'd0, RsTx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_grant", {31'd0, grant_id}, 0);
    chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
    rst = 0;
    bad = 0;
    repeat (50) begin
      step();
      if (RsTx !== 1'b1 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
    end
    chk("idle50", bad, 0);
    // single byte 0xA5
    r0_hi = 0;
    src(0, 8'hA5, 1);
    expect_frame(8'hA5, 0);
    recv("a5");
    chk("a5_ready_pulse", r0_hi, 1);
    // lone requesters win regardless of pointer; leaves pointer on requester 0
    src(0, 8'h0F, 1);
    expect_frame(8'h0F, 0);
    recv("lone0");
    src(1, 8'h3C, 1);
    expect_frame(8'h3C, 1);
    recv("lone1");
    // both valid, single-byte packets
    src(0, 8'h11, 1);
    src(1, 8'h22, 1);
    expect_frame(8'h11, 0);
    expect_frame(8'h22, 1);
    recv("b11");
    recv("b22");
    chk("b_spacing", last_start - prev_start, 41);
    // packet lock holds off requester 1
    acc_log.delete();
    src(0, 8'h01, 0);
    src(0, 8'h02, 0);
    src(0, 8'h03, 1);
    src(1, 8'h44, 1);
    expect_frame(8'h01, 0);
    expect_frame(8'h02, 0);
    expect_frame(8'h03, 0);
    expect_frame(8'h44, 1);
    recv("p01");
    recv("p02");
    recv("p03");
    recv("p44");
    chk("order0", acc_log.size() > 0 ? acc_log[0] : 9'h1FF, 9'h001);
    chk("order1", acc_log.size() > 1 ? acc_log[1] : 9'h1FF, 9'h002);
    chk("order2", acc_log.size() > 2 ? acc_log[2] : 9'h1FF, 9'h003);
    chk("order3", acc_log.size() > 3 ? acc_log[3] : 9'h1FF, 9'h144);
    // lock holder goes quiet mid-packet
    src(0, 8'h55, 0);
    src(1, 8'h66, 1);
    expect_frame(8'h55, 0);
    recv("d55");
    bad = 0;
    repeat (100) begin
      step();
      if (RsTx !== 1'b1 || busy !== 1'b0 || req1_ready !== 1'b0 || req1_valid !== 1'b1) bad++;
    end
    chk("lock_hold", bad, 0);
    chk("lock_grant", {31'd0, grant_id}, 0);
    src(0, 8'h77, 1);
    expect_frame(8'h77, 0);
    expect_frame(8'h66, 1);
    recv("d77");
    recv("d66");
    // reset during data bit 3 of a locking byte from requester 1
    src(1, 8'hC3, 0);
    n = 0;
    while (RsTx !== 1'b0 && n < 500) begin step(); n++; end
    chk("e_start_seen", {31'd0, n < 500}, 1);
    repeat (17) step();
    chk("e_bit3", {31'd0, RsTx}, 0);
    chk("e_grant_pre", {31'd0, grant_id}, 1);
    rst = 1;
    #1;
    chk("e_rst_tx", {31'd0, RsTx}, 1);
    chk("e_rst_busy", {31'd0, busy}, 0);
    chk("e_rst_grant", {31'd0, grant_id}, 0);
    repeat (2) step();
    rst = 0;
    src(0, 8'h96, 1);
    src(1, 8'h69, 1);
    expect_frame(8'h96, 0);
    expect_frame(8'h69, 1);
    recv("f96");
    recv("f69");
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
